// File: rtl/ram_arbiter.sv
// Single-port byte RAM shared by N requesters through a req/gnt handshake.
// Supports fixed or round-robin priority, locked bursts and one-cycle read strobes.
module ram_arbiter #(
  parameter int D  = 8,
  parameter int N  = 2,
  parameter int RR = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   write,
  input  logic [N*D-1:0] addr,
  input  logic [N*8-1:0] d_in,
  input  logic [N-1:0]   lock,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   rd_valid,
  output logic [7:0]     d_out
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [7:0]    mem [0:(1<<D)-1];
  logic          own_vld;
  logic [IW-1:0] own_idx;
  logic [IW-1:0] ptr;

  logic          own_hit_p0;
  logic [IW-1:0] sel_p0;
  logic          acc_p0;
  logic          wr_p0;
  logic [D-1:0]  addr_p0;
  logic [7:0]    din_p0;

  function automatic logic [IW-1:0] pick_fixed(input logic [N-1:0] r);
    pick_fixed = '0;
    for (int k = N - 1; k >= 0; k--)
      if (r[k]) pick_fixed = IW'(k);
  endfunction

  // Requesters above ptr are served first, then the wrap-around part up to ptr.
  function automatic logic [IW-1:0] pick_rr(input logic [N-1:0] r, input logic [IW-1:0] p);
    logic found;
    found   = 1'b0;
    pick_rr = '0;
    for (int k = 0; k < N; k++)
      if (!found && r[k] && (IW'(k) > p)) begin
        pick_rr = IW'(k);
        found   = 1'b1;
      end
    for (int k = 0; k < N; k++)
      if (!found && r[k] && (IW'(k) <= p)) begin
        pick_rr = IW'(k);
        found   = 1'b1;
      end
  endfunction

  // Stage p0: grant selection and access decode
  always_comb begin
    own_hit_p0 = own_vld && lock[own_idx] && req[own_idx];
    if (own_hit_p0)
      sel_p0 = own_idx;
    else if (RR != 0)
      sel_p0 = pick_rr(req, ptr);
    else
      sel_p0 = pick_fixed(req);
    gnt = '0;
    for (int i = 0; i < N; i++)
      gnt[i] = rst && (|req) && (sel_p0 == IW'(i));
    acc_p0  = |gnt;
    wr_p0   = write[sel_p0];
    addr_p0 = addr[sel_p0*D +: D];
    din_p0  = d_in[sel_p0*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (acc_p0 && wr_p0)
      mem[addr_p0] <= din_p0;
  end

  // Stage p1: ownership, pointer and read return
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      own_vld  <= 1'b0;
      own_idx  <= '0;
      ptr      <= IW'(N - 1);
      rd_valid <= '0;
      d_out    <= '0;
    end else begin
      rd_valid <= '0;
      if (acc_p0) begin
        own_vld <= 1'b1;
        own_idx <= sel_p0;
        if (RR != 0)
          ptr <= sel_p0;
        if (!wr_p0) begin
          rd_valid <= gnt;
          d_out    <= mem[addr_p0];
        end
      end else begin
        own_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a fixed-priority N=2 instance and a round-robin N=3 instance
// driven by directed and random traffic, compared against an array-based reference model.
module tb_ram_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  a_req, a_wr, a_lock, a_gnt, a_rv;
  logic [15:0] a_addr, a_din;
  logic [7:0]  a_do;
  logic [2:0]  b_req, b_wr, b_lock, b_gnt, b_rv;
  logic [23:0] b_addr, b_din;
  logic [7:0]  b_do;

  int n_tests = 0;
  int n_fail  = 0;

  ram_arbiter #(.D(8), .N(2), .RR(0)) u_fix (
    .clk(clk), .rst(rst_n), .req(a_req), .write(a_wr), .addr(a_addr), .d_in(a_din),
    .lock(a_lock), .gnt(a_gnt), .rd_valid(a_rv), .d_out(a_do));

  ram_arbiter #(.D(8), .N(3), .RR(1)) u_rr (
    .clk(clk), .rst(rst_n), .req(b_req), .write(b_wr), .addr(b_addr), .d_in(b_din),
    .lock(b_lock), .gnt(b_gnt), .rd_valid(b_rv), .d_out(b_do));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, slot 0 = fixed instance, slot 1 = round-robin instance
  int         nn [2]  = '{2, 3};
  int         rrm [2] = '{0, 1};
  int         m_owner [2];
  int         m_ptr [2];
  logic [7:0] m_mem [2][256];
  logic [2:0] m_rv [2];
  logic [7:0] m_do [2];
  int         ga = -1;
  int         gb = -1;
  logic [1:0] gnt_a;
  logic [2:0] gnt_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] oh(input int g);
    return (g < 0) ? 32'd0 : (32'd1 << g);
  endfunction

  function automatic int pick(input int s, input logic [2:0] r, input logic [2:0] lk);
    int o;
    int j;
    logic [1:0] oi;
    o = m_owner[s];
    if (o >= 0) begin
      oi = 2'(o);
      if (lk[oi] && r[oi]) return o;
    end
    for (int k = 1; k <= nn[s]; k++) begin
      j = rrm[s] != 0 ? (m_ptr[s] + k) % nn[s] : k - 1;
      if (r[2'(j)]) return j;
    end
    return -1;
  endfunction

  task automatic mstep(input int s, input int g, input logic [2:0] w,
                       input logic [23:0] ad, input logic [23:0] dn);
    m_rv[s] = 3'd0;
    if (g < 0) begin
      m_owner[s] = -1;
      return;
    end
    m_owner[s] = g;
    if (rrm[s] != 0) m_ptr[s] = g;
    if (w[2'(g)]) m_mem[s][ad[g*8 +: 8]] = dn[g*8 +: 8];
    else begin
      m_do[s] = m_mem[s][ad[g*8 +: 8]];
      m_rv[s] = 3'(1 << g);
    end
  endtask

  task automatic mreset();
    for (int s = 0; s < 2; s++) begin
      m_owner[s] = -1;
      m_ptr[s]   = nn[s] - 1;
      m_rv[s]    = 3'd0;
      m_do[s]    = 8'd0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    ga = rst_n ? pick(0, {1'b0, a_req}, {1'b0, a_lock}) : -1;
    gb = rst_n ? pick(1, b_req, b_lock) : -1;
    gnt_a = a_gnt;
    gnt_b = b_gnt;
    check("gnt_a", 32'(a_gnt), oh(ga));
    check("gnt_b", 32'(b_gnt), oh(gb));
    @(posedge clk);
    if (rst_n) begin
      mstep(0, ga, {1'b0, a_wr}, {8'h00, a_addr}, {8'h00, a_din});
      mstep(1, gb, b_wr, b_addr, b_din);
    end
    #1;
    check("rv_a", 32'(a_rv), 32'(m_rv[0]));
    check("dout_a", 32'(a_do), 32'(m_do[0]));
    check("rv_b", 32'(b_rv), 32'(m_rv[1]));
    check("dout_b", 32'(b_do), 32'(m_do[1]));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mreset();
    #1;
    check("rst_gnt_a", 32'(a_gnt), 32'd0);
    check("rst_gnt_b", 32'(b_gnt), 32'd0);
    check("rst_rv_a", 32'(a_rv), 32'd0);
    check("rst_rv_b", 32'(b_rv), 32'd0);
    check("rst_do_a", 32'(a_do), 32'd0);
    check("rst_do_b", 32'(b_do), 32'd0);
    a_req = '0;
    b_req = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ga = -1;
    gb = -1;
  endtask

  task automatic rand_run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < 2; i++)
        if (!a_req[i] || ga == i || $urandom_range(15) == 0) begin
          a_req[i]  = 1'($urandom_range(1));
          a_wr[i]   = 1'($urandom_range(1));
          a_lock[i] = ($urandom_range(3) == 0);
          a_addr[i*8 +: 8] = 8'($urandom_range(63));
          a_din[i*8 +: 8]  = 8'($urandom);
        end
      for (int i = 0; i < 3; i++)
        if (!b_req[i] || gb == i || $urandom_range(15) == 0) begin
          b_req[i]  = 1'($urandom_range(1));
          b_wr[i]   = 1'($urandom_range(1));
          b_lock[i] = ($urandom_range(3) == 0);
          b_addr[i*8 +: 8] = 8'($urandom_range(63));
          b_din[i*8 +: 8]  = 8'($urandom);
        end
      tick();
    end
  endtask

  logic [2:0] rr_seq [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

  initial begin
    rst_n  = 1'b0;
    a_req  = '0; a_wr = '0; a_lock = '0; a_addr = '0; a_din = '0;
    b_req  = '0; b_wr = '0; b_lock = '0; b_addr = '0; b_din = '0;
    apply_reset();

    // fill both memories with a known pattern
    for (int a = 0; a < 256; a++) begin
      a_req = 2'b01; a_wr = 2'b01; a_addr = {8'h00, 8'(a)}; a_din = {8'h00, 8'(a) ^ 8'hC3};
      b_req = 3'b001; b_wr = 3'b001; b_addr = {16'h0000, 8'(a)}; b_din = {16'h0000, 8'(a) ^ 8'h3C};
      tick();
    end
    b_req = '0;

    // two contending reads, fixed priority
    a_req = 2'b01; a_wr = 2'b01; a_addr = 16'h0010; a_din = 16'h00AA; tick();
    a_addr = 16'h0020; a_din = 16'h0055; tick();
    a_req = 2'b11; a_wr = 2'b00; a_addr = 16'h2010; tick();
    check("t1_gnt0", 32'(gnt_a), 32'h1);
    check("t1_rv0", 32'(a_rv), 32'h1);
    check("t1_d0", 32'(a_do), 32'hAA);
    a_req = 2'b10; tick();
    check("t1_gnt1", 32'(gnt_a), 32'h2);
    check("t1_rv1", 32'(a_rv), 32'h2);
    check("t1_d1", 32'(a_do), 32'h55);
    a_req = '0;

    // round-robin rotation from reset
    apply_reset();
    b_req = 3'b111; b_wr = 3'b000; b_addr = 24'h030201;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t2_gnt", 32'(gnt_b), 32'(rr_seq[k]));
      check("t2_rv", 32'(b_rv), 32'(rr_seq[k]));
    end
    b_req = '0;

    // locked write burst by requester 1 with requester 0 contending
    a_req = 2'b10; a_lock = 2'b10; a_wr = 2'b10;
    for (int k = 0; k < 4; k++) begin
      a_addr[15:8] = 8'(8'h40 + k);
      a_din[15:8]  = 8'(8'hE0 + k);
      if (k == 1) begin
        a_req[0] = 1'b1; a_wr[0] = 1'b0; a_addr[7:0] = 8'h00;
      end
      tick();
      check("t3_burst_gnt", 32'(gnt_a), 32'h2);
    end
    a_req[1] = 1'b0; a_lock = 2'b00;
    tick();
    check("t3_after_gnt", 32'(gnt_a), 32'h1);
    check("t3_after_d", 32'(a_do), 32'hC3);
    for (int k = 0; k < 4; k++) begin
      a_req = 2'b01; a_wr = 2'b00; a_addr = {8'h00, 8'(8'h40 + k)};
      tick();
      check("t3_rb_rv", 32'(a_rv), 32'h1);
      check("t3_rb_d", 32'(a_do), 32'(8'hE0 + k));
    end

    // write followed by read of the same address
    a_req = 2'b01; a_wr = 2'b01; a_addr = 16'h007F; a_din = 16'h005A;
    tick();
    check("t4_wr_rv", 32'(a_rv), 32'h0);
    a_wr = 2'b00;
    tick();
    check("t4_rd_rv", 32'(a_rv), 32'h1);
    check("t4_rd_d", 32'(a_do), 32'h5A);
    a_req = '0;

    // reset while a read grant is pending
    b_req = 3'b001; b_wr = 3'b000; b_addr = 24'h000005;
    apply_reset();
    check("t5_rv_rel", 32'(b_rv), 32'h0);
    check("t5_do_rel", 32'(b_do), 32'h0);
    b_req = 3'b111; b_wr = 3'b000; b_addr = 24'h090807;
    tick();
    check("t5_first_gnt", 32'(gnt_b), 32'h1);
    b_req = '0;
    tick();

    // idle
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t6_gnt_a", 32'(gnt_a), 32'h0);
      check("t6_gnt_b", 32'(gnt_b), 32'h0);
    end

    rand_run(2000);
    apply_reset();
    rand_run(1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
